// File: rtl/zl_dvbs_pkg.sv
// Shared DVB-S transport adaptation defaults, counter widths and randomizer state encodings.
package zl_dvbs_pkg;

   localparam int unsigned DEF_PACKET_LEN = 188;
   localparam int unsigned DEF_GROUP_LEN  = 8;
   localparam logic [7:0]  DEF_SYNC_BYTE  = 8'h47;
   localparam int unsigned DEF_LFSR_WIDTH = 15;
   localparam logic [15:0] DEF_LFSR_POLY  = 16'b1100000000000001;
   localparam logic [14:0] DEF_LFSR_INIT  = 15'b000000010101001;

   // Sized for the largest legal PACKET_LEN (255) and GROUP_LEN (16).
   localparam int unsigned BYTE_CNT_W = 8;
   localparam int unsigned PKT_CNT_W  = 4;

   typedef enum logic [1:0] {
      S_hunt       = 2'd0,
      S_group_sync = 2'd1,
      S_pkt_sync   = 2'd2,
      S_data       = 2'd3
   } rand_state_e;

endpackage

// File: rtl/zl_lfsr.sv
// Byte-parallel Fibonacci PRBS: each advance shifts eight bit-steps, emitting them MSB-first on prbs_c.
module zl_lfsr
   import zl_dvbs_pkg::*;
#(
   parameter int unsigned      WIDTH = DEF_LFSR_WIDTH,
   parameter logic [WIDTH:0]   POLY  = DEF_LFSR_POLY,
   parameter logic [WIDTH-1:0] INIT  = DEF_LFSR_INIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stall,
   input  logic       clear,
   output logic [7:0] prbs_c
);

   // POLY bit k taps register stage k-1; bit 0 is the implicit constant term.
   localparam logic [WIDTH-1:0] TAPS = POLY[WIDTH:1];

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] walk_c;
   logic             fb_c;

   always_comb begin
      walk_c = state_q;
      fb_c   = 1'b0;
      prbs_c = '0;
      for (int i = 0; i < 8; i++) begin
         fb_c               = ^(walk_c & TAPS);
         prbs_c[3'(7 - i)]  = fb_c;
         walk_c             = {walk_c[WIDTH-2:0], fb_c};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
      end else if (clear) begin
         state_q <= INIT;
      end else if (!stall) begin
         state_q <= walk_c;
      end
   end

endmodule

// File: rtl/zl_tm_adapt_randomizer.sv
// Transport-stream adaptation and energy-dispersal randomizer: aligns to sync bytes,
// inverts the group sync byte and XORs payload bytes with the PRBS, with zero latency.
module zl_tm_adapt_randomizer
   import zl_dvbs_pkg::*;
#(
   parameter int unsigned           PACKET_LEN = DEF_PACKET_LEN,
   parameter int unsigned           GROUP_LEN  = DEF_GROUP_LEN,
   parameter logic [7:0]            SYNC_BYTE  = DEF_SYNC_BYTE,
   parameter int unsigned           LFSR_WIDTH = DEF_LFSR_WIDTH,
   parameter logic [LFSR_WIDTH:0]   LFSR_POLY  = DEF_LFSR_POLY,
   parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = DEF_LFSR_INIT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bypass,
   input  logic       data_in_req,
   output logic       data_in_ack,
   input  logic [7:0] data_in,
   output logic       data_out_req,
   input  logic       data_out_ack,
   output logic [7:0] data_out,
   output logic       data_out_gsop,
   output logic       sync_lost,
   output logic       locked
);

   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(PACKET_LEN - 1);
   localparam logic [PKT_CNT_W-1:0]  LAST_PKT  = PKT_CNT_W'(GROUP_LEN - 1);

   rand_state_e           state_q, state_d;
   logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic                  byp_q, byp_d;
   logic                  sync_lost_d;
   logic                  lfsr_stall_c;
   logic                  lfsr_clear_c;
   logic [7:0]            prbs_c;
   logic                  is_sync_c;

   assign is_sync_c = (data_in == SYNC_BYTE);

   zl_lfsr #(
      .WIDTH (LFSR_WIDTH),
      .POLY  (LFSR_POLY),
      .INIT  (LFSR_INIT)
   ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .stall  (lfsr_stall_c),
      .clear  (lfsr_clear_c),
      .prbs_c (prbs_c)
   );

   // Next-state, handshake and datapath; a byte moves only when data_out_ack is seen with a valid output.
   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      pkt_cnt_d     = pkt_cnt_q;
      byp_d         = byp_q;
      sync_lost_d   = 1'b0;
      lfsr_stall_c  = 1'b1;
      lfsr_clear_c  = 1'b0;
      data_out_req  = 1'b0;
      data_in_ack   = 1'b0;
      data_out      = data_in;
      data_out_gsop = 1'b0;

      case (state_q)
         S_hunt, S_group_sync, S_pkt_sync: begin
            if (data_in_req) begin
               if (is_sync_c) begin
                  data_out_req = 1'b1;
                  data_in_ack  = data_out_ack;
                  if (state_q == S_pkt_sync) begin
                     lfsr_stall_c = !data_out_ack;
                  end else begin
                     data_out_gsop = 1'b1;
                     data_out      = bypass ? SYNC_BYTE : ~SYNC_BYTE;
                     if (data_out_ack) begin
                        byp_d     = bypass;
                        pkt_cnt_d = '0;
                     end
                  end
                  if (data_out_ack) begin
                     byte_cnt_d = BYTE_CNT_W'(1);
                     state_d    = S_data;
                  end
               end else begin
                  // Non-sync bytes are always swallowed; at a packet start they also break lock.
                  data_in_ack = 1'b1;
                  if (state_q != S_hunt) begin
                     sync_lost_d  = 1'b1;
                     state_d      = S_hunt;
                     byte_cnt_d   = '0;
                     pkt_cnt_d    = '0;
                     lfsr_clear_c = 1'b1;
                  end
               end
            end
         end

         S_data: begin
            if (data_in_req) begin
               data_out_req = 1'b1;
               data_in_ack  = data_out_ack;
               data_out     = data_in ^ (byp_q ? 8'h00 : prbs_c);
               if (data_out_ack) begin
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_d = '0;
                     if (pkt_cnt_q == LAST_PKT) begin
                        pkt_cnt_d    = '0;
                        state_d      = S_group_sync;
                        lfsr_clear_c = 1'b1;
                     end else begin
                        pkt_cnt_d    = pkt_cnt_q + PKT_CNT_W'(1);
                        state_d      = S_pkt_sync;
                        lfsr_stall_c = 1'b0;
                     end
                  end else begin
                     byte_cnt_d   = byte_cnt_q + BYTE_CNT_W'(1);
                     lfsr_stall_c = 1'b0;
                  end
               end
            end
         end

         default: begin
            state_d      = S_hunt;
            byte_cnt_d   = '0;
            pkt_cnt_d    = '0;
            lfsr_clear_c = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_hunt;
         byte_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         byp_q      <= 1'b0;
         sync_lost  <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         byp_q      <= byp_d;
         sync_lost  <= sync_lost_d;
         locked     <= (state_d != S_hunt);
      end
   end

endmodule

// File: tb/tb_zl_tm_adapt_randomizer.sv
// Scoreboard bench: directed streams into a default instance and a 16-byte/2-packet instance.
`timescale 1ns/1ps
module tb_zl_tm_adapt_randomizer;

   typedef struct {
      logic [7:0] data;
      logic       gsop;
   } exp_t;

   typedef struct {
      int   kind;
      int   dut;
      logic locked;
      logic sl;
   } st_t;

   localparam int ST_LEVEL   = 0;
   localparam int ST_TIMEOUT = 1;
   localparam int ST_DRAIN   = 2;
   localparam int NBITS      = 1504 * 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       stall_en;
   logic       bypass  [2];
   logic       in_req  [2];
   logic [7:0] din     [2];
   logic       out_ack [2];
   logic       in_ack  [2];
   logic       out_req [2];
   logic [7:0] dout    [2];
   logic       gsop    [2];
   logic       sl      [2];
   logic       lk      [2];

   exp_t exp_q0[$];
   exp_t exp_q1[$];
   st_t  st_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference PRBS as a plain bit sequence from the register-preload definition.
   logic       seq [0:NBITS+14];
   int         m_k;
   logic       m_byp;

   exp_t mon_e;
   st_t  mon_s;
   logic mon_has;

   always #5 clk = ~clk;

   zl_tm_adapt_randomizer u_dut_a (
      .clk(clk), .rst_n(rst_n), .bypass(bypass[0]),
      .data_in_req(in_req[0]), .data_in_ack(in_ack[0]), .data_in(din[0]),
      .data_out_req(out_req[0]), .data_out_ack(out_ack[0]), .data_out(dout[0]),
      .data_out_gsop(gsop[0]), .sync_lost(sl[0]), .locked(lk[0])
   );

   zl_tm_adapt_randomizer #(.PACKET_LEN(16), .GROUP_LEN(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bypass(bypass[1]),
      .data_in_req(in_req[1]), .data_in_ack(in_ack[1]), .data_in(din[1]),
      .data_out_req(out_req[1]), .data_out_ack(out_ack[1]), .data_out(dout[1]),
      .data_out_gsop(gsop[1]), .sync_lost(sl[1]), .locked(lk[1])
   );

   function automatic logic [7:0] prbs_b(input int k);
      logic [7:0] b;
      b = '0;
      for (int j = 0; j < 8; j++) b[3'(7 - j)] = seq[15 + 8 * k + j];
      return b;
   endfunction

   task automatic push(input int s, input logic [7:0] d, input logic g);
      exp_t e;
      e.data = d;
      e.gsop = g;
      if (s == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic push_status(input int kind, input int s, input logic l, input logic y);
      st_t t;
      t.kind   = kind;
      t.dut    = s;
      t.locked = l;
      t.sl     = y;
      st_q.push_back(t);
   endtask

   task automatic expect_level(input int s, input logic l, input logic y);
      push_status(ST_LEVEL, s, l, y);
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int s, input logic [7:0] b);
      logic got;
      int   n;
      got       = 1'b0;
      n         = 0;
      din[s]    = b;
      in_req[s] = 1'b1;
      while (!got && n < 64) begin
         @(negedge clk);
         got = in_ack[s];
         n++;
         @(posedge clk);
         #1;
      end
      in_req[s] = 1'b0;
      if (!got) push_status(ST_TIMEOUT, s, 1'b0, 1'b0);
   endtask

   // One packet at position pidx in its group; pat=0 gives an all-zero payload.
   task automatic pkt(input int s, input int pidx, input int pat);
      int         plen;
      logic [7:0] d;
      plen = (s == 0) ? 188 : 16;
      if (pidx == 0) begin
         m_byp = bypass[s];
         m_k   = 0;
         push(s, m_byp ? 8'h47 : 8'hB8, 1'b1);
      end else begin
         push(s, 8'h47, 1'b0);
         m_k++;
      end
      send(s, 8'h47);
      for (int i = 1; i < plen; i++) begin
         d = (pat == 0) ? 8'h00 : 8'(pat * 31 + i * 7);
         push(s, d ^ (m_byp ? 8'h00 : prbs_b(m_k)), 1'b0);
         m_k++;
         send(s, d);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      in_req[0] = 1'b0;
      in_req[1] = 1'b0;
      expect_level(0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_k   = 0;
   endtask

   task automatic check_out(input int d, input logic has, input exp_t e,
                            input logic [7:0] act, input logic g);
      total++;
      if (!has) begin
         bad++;
         $display("FAIL out%0d_extra: got data=%h gsop=%b, required no output byte", d, act, g);
      end else if (act !== e.data || g !== e.gsop) begin
         bad++;
         $display("FAIL out%0d_byte: got data=%h gsop=%b, required data=%h gsop=%b",
                  d, act, g, e.data, e.gsop);
      end
   endtask

   task automatic check_status(input st_t t);
      total++;
      case (t.kind)
         ST_LEVEL: begin
            if (lk[t.dut] !== t.locked || sl[t.dut] !== t.sl) begin
               bad++;
               $display("FAIL status_dut%0d: locked=%b sync_lost=%b, required locked=%b sync_lost=%b",
                        t.dut, lk[t.dut], sl[t.dut], t.locked, t.sl);
            end
         end
         ST_TIMEOUT: begin
            bad++;
            $display("FAIL ack_timeout_dut%0d: data_in_ack stayed 0 for 64 cycles, required 1", t.dut);
         end
         default: begin
            if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
               bad++;
               $display("FAIL drain: %0d/%0d bytes never produced, required 0/0",
                        exp_q0.size(), exp_q1.size());
            end
         end
      endcase
   endtask

   // Monitor: compares every transferred byte and any queued status check.
   always @(negedge clk) begin
      if (out_req[0] && out_ack[0]) begin
         mon_has = (exp_q0.size() > 0);
         if (mon_has) mon_e = exp_q0.pop_front();
         check_out(0, mon_has, mon_e, dout[0], gsop[0]);
      end
      if (out_req[1] && out_ack[1]) begin
         mon_has = (exp_q1.size() > 0);
         if (mon_has) mon_e = exp_q1.pop_front();
         check_out(1, mon_has, mon_e, dout[1], gsop[1]);
      end
      if (st_q.size() > 0) begin
         mon_s = st_q.pop_front();
         check_status(mon_s);
      end
   end

   // Backpressure on the default instance when enabled.
   initial begin
      out_ack[0] = 1'b1;
      out_ack[1] = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ack[0] = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      logic [1:15] rinit;
      rinit = 15'b100101010000000;
      for (int k = 1; k <= 15; k++) seq[15 - k] = rinit[k];
      for (int j = 0; j < NBITS; j++) seq[15 + j] = seq[1 + j] ^ seq[j];

      rst_n    = 1'b0;
      stall_en = 1'b0;
      m_k      = 0;
      m_byp    = 1'b0;
      for (int s = 0; s < 2; s++) begin
         bypass[s] = 1'b0;
         in_req[s] = 1'b0;
         din[s]    = 8'h00;
      end
      do_reset();
      expect_level(0, 1'b0, 1'b0);
      expect_level(1, 1'b0, 1'b0);

      // Hunt drops non-sync bytes, then first group bytes.
      send(0, 8'h00);
      send(0, 8'h12);
      expect_level(0, 1'b0, 1'b0);
      push(0, 8'hB8, 1'b1);
      send(0, 8'h47);
      push(0, 8'h03, 1'b0);
      send(0, 8'h00);
      push(0, 8'hF6, 1'b0);
      send(0, 8'h00);
      expect_level(0, 1'b1, 1'b0);

      // Mid-packet reset: zeros are dropped until a new sync.
      do_reset();
      send(0, 8'h00);
      send(0, 8'h00);
      expect_level(0, 1'b0, 1'b0);

      // Eight full zero packets plus the start of the next group.
      for (int p = 0; p < 9; p++) pkt(0, p % 8, 0);
      expect_level(0, 1'b1, 1'b0);

      // Bad sync at packet 3.
      do_reset();
      pkt(0, 0, 1);
      pkt(0, 1, 2);
      send(0, 8'h46);
      expect_level(0, 1'b0, 1'b1);
      expect_level(0, 1'b0, 1'b0);
      send(0, 8'h11);
      pkt(0, 0, 3);
      expect_level(0, 1'b1, 1'b0);

      // Random output backpressure.
      do_reset();
      stall_en = 1'b1;
      pkt(0, 0, 4);
      pkt(0, 1, 5);
      pkt(0, 2, 0);
      stall_en = 1'b0;

      // bypass raised mid-group, effective from the next group only.
      do_reset();
      pkt(0, 0, 6);
      bypass[0] = 1'b1;
      for (int p = 1; p < 8; p++) pkt(0, p, 7);
      pkt(0, 0, 8);
      bypass[0] = 1'b0;
      pkt(0, 1, 9);
      expect_level(0, 1'b1, 1'b0);

      // Short packets and groups on the second instance.
      do_reset();
      for (int p = 0; p < 5; p++) pkt(1, p % 2, p + 1);
      expect_level(1, 1'b1, 1'b0);

      push_status(ST_DRAIN, 0, 1'b0, 1'b0);
      for (int n = 0; n < 20 && st_q.size() != 0; n++) @(posedge clk);
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
